// File: rtl/data_cache_if.sv
//------------------------------------------------------------------------------
// Module      : data_cache_if
// Description : CPU request/response and backing-memory bus of the data cache.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface data_cache_if #(
    parameter int LINE_BITS = 128
);
    logic                 is_input_valid;
    logic [31:0]          addr;
    logic [31:0]          din;
    logic                 mem_read;
    logic                 mem_write;
    logic [31:0]          dout;
    logic                 is_ready;
    logic                 is_output_valid;
    logic                 is_hit;
    logic                 mreq_valid;
    logic                 mreq_write;
    logic [31:0]          mreq_addr;
    logic [LINE_BITS-1:0] mreq_data;
    logic                 mreq_ready;
    logic                 mresp_valid;
    logic [LINE_BITS-1:0] mresp_data;

    // Cache side
    modport slave (
        input  is_input_valid, addr, din, mem_read, mem_write,
        input  mreq_ready, mresp_valid, mresp_data,
        output dout, is_ready, is_output_valid, is_hit,
        output mreq_valid, mreq_write, mreq_addr, mreq_data
    );

    // Requester / memory side
    modport master (
        output is_input_valid, addr, din, mem_read, mem_write,
        output mreq_ready, mresp_valid, mresp_data,
        input  dout, is_ready, is_output_valid, is_hit,
        input  mreq_valid, mreq_write, mreq_addr, mreq_data
    );
endinterface

`default_nettype wire

// File: rtl/data_cache.sv
//------------------------------------------------------------------------------
// Module      : data_cache
// Description : Direct-mapped, write-back / write-allocate data cache.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module data_cache #(
    parameter int NUM_SETS   = 16,
    parameter int LINE_WORDS = 4
) (
    input  logic         clk,
    input  logic         reset,
    data_cache_if.slave  bus
);

    localparam int LINE_BITS   = LINE_WORDS * 32;
    localparam int WORD_BITS   = $clog2(LINE_WORDS);
    localparam int OFFSET_BITS = WORD_BITS + 2;
    localparam int INDEX_BITS  = $clog2(NUM_SETS);
    localparam int TAG_BITS    = 32 - OFFSET_BITS - INDEX_BITS;

    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_WRITEBACK = 2'd1;
    localparam logic [1:0] ST_FILL_REQ  = 2'd2;
    localparam logic [1:0] ST_FILL_WAIT = 2'd3;

    logic [1:0]           state_q, state_d;
    logic [NUM_SETS-1:0]  valid_q;
    logic [NUM_SETS-1:0]  dirty_q;
    logic [TAG_BITS-1:0]  tag_q  [NUM_SETS];
    logic [LINE_BITS-1:0] data_q [NUM_SETS];

    logic [TAG_BITS-1:0]   req_tag;
    logic [INDEX_BITS-1:0] req_index;
    logic [WORD_BITS-1:0]  req_word;
    logic [WORD_BITS+4:0]  word_base;
    logic [31:0]           rd_word;
    logic                  req_active;
    logic                  hit;
    logic                  victim_dirty;
    logic                  write_hit;
    logic                  wb_done;
    logic                  fill_en;
    logic                  unused_addr_bits;

    assign req_tag          = bus.addr[31 -: TAG_BITS];
    assign req_index        = bus.addr[OFFSET_BITS +: INDEX_BITS];
    assign req_word         = bus.addr[2 +: WORD_BITS];
    assign word_base        = {req_word, 5'd0};
    assign rd_word          = data_q[req_index][word_base +: 32];
    assign unused_addr_bits = &{1'b0, bus.addr[1:0]};

    // Reset forces the lookup off so reset-cycle outputs are clean even with X state
    assign req_active   = !reset && (state_q == ST_IDLE) && bus.is_input_valid
                          && (bus.mem_read ^ bus.mem_write);
    assign hit          = req_active && valid_q[req_index] && (tag_q[req_index] == req_tag);
    assign victim_dirty = valid_q[req_index] && dirty_q[req_index];
    assign write_hit    = hit && bus.mem_write;
    assign wb_done      = !reset && (state_q == ST_WRITEBACK) && bus.mreq_ready;
    assign fill_en      = !reset && (state_q == ST_FILL_WAIT) && bus.mresp_valid;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (req_active && !hit) begin
                    state_d = victim_dirty ? ST_WRITEBACK : ST_FILL_REQ;
                end
            end
            ST_WRITEBACK: begin
                if (bus.mreq_ready) state_d = ST_FILL_REQ;
            end
            ST_FILL_REQ: begin
                if (bus.mreq_ready) state_d = ST_FILL_WAIT;
            end
            ST_FILL_WAIT: begin
                if (bus.mresp_valid) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        bus.is_ready        = reset || (state_q == ST_IDLE);
        bus.is_hit          = hit;
        bus.is_output_valid = hit;
        bus.dout            = (hit && bus.mem_read) ? rd_word : 32'd0;
        bus.mreq_valid      = 1'b0;
        bus.mreq_write      = 1'b0;
        bus.mreq_addr       = 32'd0;
        bus.mreq_data       = '0;
        if (!reset) begin
            case (state_q)
                ST_WRITEBACK: begin
                    bus.mreq_valid = 1'b1;
                    bus.mreq_write = 1'b1;
                    bus.mreq_addr  = {tag_q[req_index], req_index, {OFFSET_BITS{1'b0}}};
                    bus.mreq_data  = data_q[req_index];
                end
                ST_FILL_REQ: begin
                    bus.mreq_valid = 1'b1;
                    bus.mreq_addr  = {bus.addr[31:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else begin
            if (write_hit) dirty_q[req_index] <= 1'b1;
            if (wb_done)   dirty_q[req_index] <= 1'b0;
            if (fill_en) begin
                valid_q[req_index] <= 1'b1;
                dirty_q[req_index] <= 1'b0;
            end
        end
    end

    // Tag and data arrays carry no reset; valid bits qualify them
    always_ff @(posedge clk) begin
        if (fill_en) begin
            tag_q[req_index]  <= req_tag;
            data_q[req_index] <= bus.mresp_data;
        end else if (write_hit) begin
            data_q[req_index][word_base +: 32] <= bus.din;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_data_cache.sv
//------------------------------------------------------------------------------
// Module      : tb_data_cache
// Description : Directed self-checking bench for data_cache.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_data_cache;

    logic clk;
    logic reset;
    int   vecs;
    int   errs;

    data_cache_if #(.LINE_BITS(128)) b ();

    data_cache #(
        .NUM_SETS   (16),
        .LINE_WORDS (4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (b)
    );

    always #5 clk = ~clk;

    localparam logic [127:0] LINE_A  = {32'h33333333, 32'h22222222, 32'hDEADBEEF, 32'h11110000};
    localparam logic [127:0] LINE_A2 = {32'h33333333, 32'h12345678, 32'hDEADBEEF, 32'h11110000};
    localparam logic [127:0] LINE_B  = {32'hB3B3B3B3, 32'hB2B2B2B2, 32'hB1B1B1B1, 32'hB0B0B0B0};
    localparam logic [127:0] LINE_C  = {32'hC3C3C3C3, 32'hC2C2C2C2, 32'hC1C1C1C1, 32'hC0C0C0C0};
    localparam logic [127:0] LINE_X  = {32'hEEEEEEEE, 32'hEEEEEEEE, 32'hEEEEEEEE, 32'hEEEEEEEE};

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vecs++;
        assert (obs === exp)
        else begin
            errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic req(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d);
        b.is_input_valid = 1'b1;
        b.mem_read       = rd;
        b.mem_write      = wr;
        b.addr           = a;
        b.din            = d;
    endtask

    initial begin
        clk = 1'b0;
        vecs = 0;
        errs = 0;
        reset = 1'b1;
        req(1'b1, 1'b0, 32'h0000_0104, 32'd0);
        b.mreq_ready  = 1'b0;
        b.mresp_valid = 1'b0;
        b.mresp_data  = '0;

        // Reset-cycle outputs with a request on the bus
        #1;
        chk("rst_ready", b.is_ready, 1'b1);
        chk("rst_ovalid", b.is_output_valid, 1'b0);
        chk("rst_hit", b.is_hit, 1'b0);
        chk("rst_mreq_valid", b.mreq_valid, 1'b0);
        chk("rst_dout", b.dout, 32'd0);
        tick();
        tick();
        reset = 1'b0;
        b.is_input_valid = 1'b0;
        b.mem_read = 1'b0;
        tick();

        // Cold read miss, clean fill, 3 cycles to completion
        req(1'b1, 1'b0, 32'h0000_0104, 32'd0);
        #1;
        chk("cold_hit", b.is_hit, 1'b0);
        chk("cold_ovalid", b.is_output_valid, 1'b0);
        tick();
        chk("fillreq_valid", b.mreq_valid, 1'b1);
        chk("fillreq_write", b.mreq_write, 1'b0);
        chk("fillreq_addr", b.mreq_addr, 32'h0000_0100);
        chk("fillreq_ready", b.is_ready, 1'b0);
        b.mreq_ready = 1'b1;
        tick();
        b.mreq_ready = 1'b0;
        chk("fillwait_mreq_valid", b.mreq_valid, 1'b0);
        chk("fillwait_ovalid", b.is_output_valid, 1'b0);
        b.mresp_valid = 1'b1;
        b.mresp_data  = LINE_A;
        tick();
        b.mresp_valid = 1'b0;
        chk("cold_done_hit", b.is_hit, 1'b1);
        chk("cold_done_ovalid", b.is_output_valid, 1'b1);
        chk("cold_done_dout", b.dout, 32'hDEADBEEF);
        tick();

        // Write hit then read hits, zero wait
        req(1'b0, 1'b1, 32'h0000_0108, 32'h12345678);
        #1;
        chk("whit_hit", b.is_hit, 1'b1);
        chk("whit_ovalid", b.is_output_valid, 1'b1);
        tick();
        req(1'b1, 1'b0, 32'h0000_0108, 32'd0);
        #1;
        chk("rhit_ovalid", b.is_output_valid, 1'b1);
        chk("rhit_dout", b.dout, 32'h12345678);
        tick();
        req(1'b1, 1'b0, 32'h0000_010C, 32'd0);
        #1;
        chk("rhit_w3_dout", b.dout, 32'h33333333);
        tick();

        // Dirty eviction: writeback, fill, 4 cycles
        req(1'b1, 1'b0, 32'h0000_1108, 32'd0);
        #1;
        chk("evict_hit", b.is_hit, 1'b0);
        chk("evict_ovalid", b.is_output_valid, 1'b0);
        tick();
        chk("wb_valid", b.mreq_valid, 1'b1);
        chk("wb_write", b.mreq_write, 1'b1);
        chk("wb_addr", b.mreq_addr, 32'h0000_0100);
        chk("wb_word2", b.mreq_data[95:64], 32'h12345678);
        chk("wb_line", b.mreq_data, LINE_A2);
        b.mreq_ready = 1'b1;
        tick();
        chk("evfill_write", b.mreq_write, 1'b0);
        chk("evfill_addr", b.mreq_addr, 32'h0000_1100);
        tick();
        b.mreq_ready = 1'b0;
        b.mresp_valid = 1'b1;
        b.mresp_data  = LINE_B;
        tick();
        b.mresp_valid = 1'b0;
        chk("evict_done_ovalid", b.is_output_valid, 1'b1);
        chk("evict_done_dout", b.dout, 32'hB2B2B2B2);
        tick();

        // Clean miss (dirty must have been cleared) with 5 cycles of backpressure
        req(1'b1, 1'b0, 32'h0000_0108, 32'd0);
        tick();
        for (int i = 0; i < 5; i++) begin
            chk("bp_mreq_valid", b.mreq_valid, 1'b1);
            chk("bp_mreq_write", b.mreq_write, 1'b0);
            chk("bp_mreq_addr", b.mreq_addr, 32'h0000_0100);
            chk("bp_ready", b.is_ready, 1'b0);
            tick();
        end
        b.mreq_ready = 1'b1;
        tick();
        b.mreq_ready = 1'b0;
        b.mresp_valid = 1'b1;
        b.mresp_data  = LINE_A2;
        tick();
        b.mresp_valid = 1'b0;
        chk("bp_done_dout", b.dout, 32'h12345678);
        tick();

        // Reset in FILL_WAIT, stray response afterwards must be ignored
        req(1'b1, 1'b0, 32'h0000_2204, 32'd0);
        #1;
        chk("rm_hit", b.is_hit, 1'b0);
        tick();
        chk("rm_fill_addr", b.mreq_addr, 32'h0000_2200);
        b.mreq_ready = 1'b1;
        tick();
        b.mreq_ready = 1'b0;
        chk("rm_wait_ready", b.is_ready, 1'b0);
        reset = 1'b1;
        b.is_input_valid = 1'b0;
        #1;
        chk("rm_rst_ready", b.is_ready, 1'b1);
        chk("rm_rst_mreq_valid", b.mreq_valid, 1'b0);
        tick();
        reset = 1'b0;
        chk("rm_post_ready", b.is_ready, 1'b1);
        chk("rm_post_mreq_valid", b.mreq_valid, 1'b0);
        b.mresp_valid = 1'b1;
        b.mresp_data  = LINE_X;
        tick();
        b.mresp_valid = 1'b0;
        chk("stray_ready", b.is_ready, 1'b1);
        req(1'b1, 1'b0, 32'h0000_2204, 32'd0);
        #1;
        chk("stray_rehit", b.is_hit, 1'b0);
        chk("stray_ovalid", b.is_output_valid, 1'b0);
        tick();
        chk("rm_refill_valid", b.mreq_valid, 1'b1);
        chk("rm_refill_addr", b.mreq_addr, 32'h0000_2200);
        b.mreq_ready = 1'b1;
        tick();
        b.mreq_ready = 1'b0;
        b.mresp_valid = 1'b1;
        b.mresp_data  = LINE_C;
        tick();
        b.mresp_valid = 1'b0;
        chk("rm_done_dout", b.dout, 32'hC1C1C1C1);
        tick();

        // Both or neither of read/write: ignored
        req(1'b1, 1'b1, 32'h0000_2204, 32'hFFFFFFFF);
        #1;
        chk("both_hit", b.is_hit, 1'b0);
        chk("both_ovalid", b.is_output_valid, 1'b0);
        tick();
        chk("both_ready", b.is_ready, 1'b1);
        chk("both_mreq_valid", b.mreq_valid, 1'b0);
        req(1'b0, 1'b0, 32'h0000_2204, 32'hFFFFFFFF);
        #1;
        chk("neither_ovalid", b.is_output_valid, 1'b0);
        tick();
        chk("neither_ready", b.is_ready, 1'b1);
        req(1'b1, 1'b0, 32'h0000_2204, 32'd0);
        #1;
        chk("after_both_hit", b.is_hit, 1'b1);
        chk("after_both_dout", b.dout, 32'hC1C1C1C1);
        tick();
        b.is_input_valid = 1'b0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/data_cache.md
DATA_CACHE -- requirements
Module: data_cache

Interface
REQ-001 Parameter NUM_SETS, default 16: number of direct-mapped lines; power of two.
REQ-002 Parameter LINE_WORDS, default 4: 32-bit words per line, giving a 16-byte line.
REQ-003 Port clk  in  1  single clock; all state updates on rising edge.
REQ-004 Port reset  in  1  synchronous, active-high reset, sampled on rising edge of clk.
REQ-005 Port is_input_valid  in  1  CPU request present this cycle.
REQ-006 Port addr  in  32  byte address; addr[1:0] ignored.
REQ-007 Port din  in  32  store data.
REQ-008 Port mem_read  in  1  load request.
REQ-009 Port mem_write  in  1  store request.
REQ-010 Port dout  out  32  load data; meaningful only while is_output_valid=1.
REQ-011 Port is_ready  out  1  cache is in IDLE and can look up a request.
REQ-012 Port is_output_valid  out  1  request completed this cycle.
REQ-013 Port is_hit  out  1  the current lookup hits.
REQ-014 Port mreq_valid  out  1  backing-memory request.
REQ-015 Port mreq_write  out  1  1 = line writeback, 0 = line fill.
REQ-016 Port mreq_addr  out  32  line-aligned address; bits [3:0] are 0.
REQ-017 Port mreq_data  out  128  victim line for a writeback; word 0 in bits [31:0].
REQ-018 Port mreq_ready  in  1  memory accepts the request this cycle.
REQ-019 Port mresp_valid  in  1  fill data present; one-cycle pulse.
REQ-020 Port mresp_data  in  128  fill line; word 0 in bits [31:0].

Function
REQ-021 Address split SHALL be: tag=addr[31:8], index=addr[7:4], word=addr[3:2] (defaults).
REQ-022 Each line SHALL hold valid, dirty, tag, and data; policy is write-back, write-allocate.
REQ-023 FSM states SHALL be IDLE, WRITEBACK, FILL_REQ, FILL_WAIT; is_ready=1 only in IDLE.
REQ-024 A request SHALL be active when the FSM is in IDLE, is_input_valid=1, and exactly one of mem_read/mem_write is 1; a request with both or neither set is ignored with no state change.
REQ-025 is_hit SHALL be combinational: 1 when a request is active and the indexed line is valid with a matching tag; otherwise 0.
REQ-026 Read hit: is_output_valid=1 and dout=the addressed word, in the same cycle (zero added latency).
REQ-027 Write hit: is_output_valid=1 in the same cycle; at the clock edge the word is written and dirty is set.
REQ-028 Miss: is_output_valid=0; the next state is WRITEBACK if the victim is valid and dirty, otherwise FILL_REQ.
REQ-029 The requester SHALL hold addr, din, mem_read, mem_write, and is_input_valid stable from a miss until is_output_valid=1; the cache re-looks up in IDLE after the fill.
REQ-030 WRITEBACK: mreq_valid=1, mreq_write=1, mreq_addr={victim tag, index, 4'b0}, mreq_data=victim line; hold all of these until mreq_ready=1, then go to FILL_REQ and clear dirty.
REQ-031 FILL_REQ: mreq_valid=1, mreq_write=0, mreq_addr={addr[31:4], 4'b0}; on mreq_ready=1 go to FILL_WAIT.
REQ-032 FILL_WAIT: mreq_valid=0; on mresp_valid=1, write the line, set valid=1, dirty=0, and tag, then return to IDLE.
REQ-033 mresp_valid SHALL be ignored in every state except FILL_WAIT.
REQ-034 Minimum miss penalty SHALL be 3 cycles clean and 4 cycles dirty from miss to is_output_valid, with zero-wait memory; each memory wait cycle adds 1.
REQ-035 Outputs SHALL never assert is_output_valid outside IDLE.

Reset
REQ-036 On reset: FSM→IDLE and all valid and dirty bits cleared; tag and data contents are don't-care.
REQ-037 Reset-cycle outputs: is_ready=1, is_output_valid=0, is_hit=0, mreq_valid=0, dout=0.
REQ-038 Reset mid-miss (any non-IDLE state) SHALL abandon the transaction; mreq_valid=0 from the next cycle and any later mresp_valid is ignored.

Verification
REQ-039 Cold read 0x0000_0104; memory returns line {W3..W0} with W1=0xDEADBEEF -> 1 miss, FILL_REQ with mreq_addr=0x100, then dout=0xDEADBEEF with is_hit=1, 3 cycles after the miss (zero-wait memory).
REQ-040 Write 0x0000_0108 din=0x12345678 after the REQ-039 fill, then read 0x108 -> both requests complete in 0 wait cycles; read dout=0x12345678.
REQ-041 Dirty eviction: after REQ-040, read 0x0000_1108 (same index 0, new tag) -> WRITEBACK with mreq_addr=0x100 and mreq_data[95:64]=0x12345678, then fill at 0x1100; completes in 4 cycles.
REQ-042 Backpressure: mreq_ready held at 0 for 5 cycles in FILL_REQ -> mreq_valid and mreq_addr stay stable and is_ready=0 throughout.
REQ-043 Reset in FILL_WAIT, then mresp_valid pulse, then read of the same address -> the stray response is ignored and the read misses again.
REQ-044 is_input_valid=1 with mem_read=mem_write=1 -> no miss, is_output_valid=0, and the FSM stays in IDLE.
